// File: rtl/sprite_update_scheduler.sv
// sprite_update_scheduler
//   Frame-synchronous scheduler for the sprite position registers that feed the
//   VGA renderer's box-compare colour mux. Game logic fills shadow slots through
//   a valid/ready port. A requested commit is held until the next vertical sync,
//   so the renderer never sees a half-updated frame.
//
// Ports
//   iVGA_CLK, iRST_n       pixel clock, asynchronous active-low reset
//   iVS                    active-low vsync, same clock domain
//   wr_valid/wr_ready      shadow write handshake (wr_slot, wr_x, wr_y, wr_vis)
//   commit_req             request a shadow->active copy at the next vsync
//   commit_pend            commit armed or in progress
//   commit_done            one-cycle pulse while the copy happens
//   vblank_start           one-cycle registered pulse on the iVS falling edge
//   frame_cnt              16-bit vsync counter, wraps
//   act_x/act_y/act_vis    active sprite registers, slot i at [i*W +: W]
//
// Build option
//   SPRITE_AUTO_COMMIT_EN  commit automatically at vsync when any slot was
//                          written since the last commit.
module sprite_update_scheduler #(
  parameter int NUM_SPRITES = 4,
  parameter int SLOT_W      = 2,
  parameter int X_W         = 10,
  parameter int Y_W         = 9
) (
  input  logic                       iVGA_CLK,
  input  logic                       iRST_n,
  input  logic                       iVS,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [SLOT_W-1:0]          wr_slot,
  input  logic [X_W-1:0]             wr_x,
  input  logic [Y_W-1:0]             wr_y,
  input  logic                       wr_vis,
  input  logic                       commit_req,
  output logic                       commit_pend,
  output logic                       commit_done,
  output logic                       vblank_start,
  output logic [15:0]                frame_cnt,
  output logic [NUM_SPRITES*X_W-1:0] act_x,
  output logic [NUM_SPRITES*Y_W-1:0] act_y,
  output logic [NUM_SPRITES-1:0]     act_vis
);

  typedef enum logic [1:0] {
    OPEN   = 2'd0,
    ARMED  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic                       vs_d_q;
  logic                       vblank_start_q, vblank_start_d;
  logic [15:0]                frame_cnt_q, frame_cnt_d;
  logic                       wr_ready_q, commit_pend_q, commit_done_q;
  logic [X_W-1:0]             sh_x_q   [NUM_SPRITES];
  logic [X_W-1:0]             sh_x_d   [NUM_SPRITES];
  logic [Y_W-1:0]             sh_y_q   [NUM_SPRITES];
  logic [Y_W-1:0]             sh_y_d   [NUM_SPRITES];
  logic [NUM_SPRITES-1:0]     sh_vis_q, sh_vis_d;
  logic [NUM_SPRITES*X_W-1:0] act_x_q, act_x_d;
  logic [NUM_SPRITES*Y_W-1:0] act_y_q, act_y_d;
  logic [NUM_SPRITES-1:0]     act_vis_q, act_vis_d;
  logic                       wr_fire;
`ifdef SPRITE_AUTO_COMMIT_EN
  logic                       dirty_q, dirty_d;
`endif

  // wr_ready_q always mirrors (state_q == OPEN), so it gates the handshake.
  assign wr_fire = wr_valid & wr_ready_q;

  always_comb begin
    state_d        = state_q;
    vblank_start_d = vs_d_q & ~iVS;
    frame_cnt_d    = frame_cnt_q + 16'(vblank_start_q);
    sh_x_d         = sh_x_q;
    sh_y_d         = sh_y_q;
    sh_vis_d       = sh_vis_q;
    act_x_d        = act_x_q;
    act_y_d        = act_y_q;
    act_vis_d      = act_vis_q;
`ifdef SPRITE_AUTO_COMMIT_EN
    dirty_d        = dirty_q | wr_fire;
`endif

    // Slot decode by compare: an index outside the slot range matches nothing,
    // so the handshake completes and the data is dropped.
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      if (wr_fire && (wr_slot == SLOT_W'(i))) begin
        sh_x_d[i]   = wr_x;
        sh_y_d[i]   = wr_y;
        sh_vis_d[i] = wr_vis;
      end
    end

    unique case (state_q)
      OPEN: begin
`ifdef SPRITE_AUTO_COMMIT_EN
        if (dirty_q && vblank_start_q) state_d = COMMIT;
        else if (commit_req)           state_d = ARMED;
`else
        if (commit_req) state_d = ARMED;
`endif
      end
      ARMED: begin
        if (vblank_start_q) state_d = COMMIT;
      end
      COMMIT: begin
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
          act_x_d[i*X_W +: X_W] = sh_x_q[i];
          act_y_d[i*Y_W +: Y_W] = sh_y_q[i];
          act_vis_d[i]          = sh_vis_q[i];
        end
`ifdef SPRITE_AUTO_COMMIT_EN
        dirty_d = 1'b0;
`endif
        state_d = OPEN;
      end
      default: state_d = OPEN;
    endcase
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q        <= OPEN;
      vs_d_q         <= 1'b1;
      vblank_start_q <= 1'b0;
      frame_cnt_q    <= '0;
      wr_ready_q     <= 1'b1;
      commit_pend_q  <= 1'b0;
      commit_done_q  <= 1'b0;
      sh_x_q         <= '{default: '0};
      sh_y_q         <= '{default: '0};
      sh_vis_q       <= '0;
      act_x_q        <= '0;
      act_y_q        <= '0;
      act_vis_q      <= '0;
`ifdef SPRITE_AUTO_COMMIT_EN
      dirty_q        <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      vs_d_q         <= iVS;
      vblank_start_q <= vblank_start_d;
      frame_cnt_q    <= frame_cnt_d;
      // Status outputs registered from the next state so they track state_q.
      wr_ready_q     <= (state_d == OPEN);
      commit_pend_q  <= (state_d != OPEN);
      commit_done_q  <= (state_d == COMMIT);
      sh_x_q         <= sh_x_d;
      sh_y_q         <= sh_y_d;
      sh_vis_q       <= sh_vis_d;
      act_x_q        <= act_x_d;
      act_y_q        <= act_y_d;
      act_vis_q      <= act_vis_d;
`ifdef SPRITE_AUTO_COMMIT_EN
      dirty_q        <= dirty_d;
`endif
    end
  end

  assign wr_ready     = wr_ready_q;
  assign commit_pend  = commit_pend_q;
  assign commit_done  = commit_done_q;
  assign vblank_start = vblank_start_q;
  assign frame_cnt    = frame_cnt_q;
  assign act_x        = act_x_q;
  assign act_y        = act_y_q;
  assign act_vis      = act_vis_q;

endmodule

// File: tb/tb_sprite_update_scheduler.sv
// Directed bench for sprite_update_scheduler. Slot index widened to 3 bits so
// that an out-of-range slot (5) can be presented with four sprites.
module tb_sprite_update_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vs;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_slot;
  logic [9:0]  wr_x;
  logic [8:0]  wr_y;
  logic        wr_vis;
  logic        commit_req;
  logic        commit_pend;
  logic        commit_done;
  logic        vblank_start;
  logic [15:0] frame_cnt;
  logic [39:0] act_x;
  logic [35:0] act_y;
  logic [3:0]  act_vis;

  int n_vec = 0;
  int n_err = 0;
  int seen;
  logic [39:0] ex_x;
  logic [35:0] ex_y;

  always #5 clk = ~clk;

  sprite_update_scheduler #(
    .NUM_SPRITES(4),
    .SLOT_W     (3),
    .X_W        (10),
    .Y_W        (9)
  ) dut (
    .iVGA_CLK    (clk),
    .iRST_n      (rst_n),
    .iVS         (vs),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_slot     (wr_slot),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_vis      (wr_vis),
    .commit_req  (commit_req),
    .commit_pend (commit_pend),
    .commit_done (commit_done),
    .vblank_start(vblank_start),
    .frame_cnt   (frame_cnt),
    .act_x       (act_x),
    .act_y       (act_y),
    .act_vis     (act_vis)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [2:0] s, input logic [9:0] x, input logic [8:0] y,
                     input logic v);
    wr_valid = 1'b1; wr_slot = s; wr_x = x; wr_y = y; wr_vis = v;
  endtask

  initial begin
    rst_n = 1'b0; vs = 1'b1; wr_valid = 1'b0; wr_slot = '0; wr_x = '0;
    wr_y = '0; wr_vis = 1'b0; commit_req = 1'b0;
    #12;
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_pend", commit_pend, 0);
    chk("rst_done", commit_done, 0);
    chk("rst_vblank", vblank_start, 0);
    chk("rst_frame", frame_cnt, 0);
    chk("rst_act_x", act_x, 0);
    chk("rst_act_vis", act_vis, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    tick(2);

    // Basic commit: slot1 x=100 y=50 visible
    put(3'd1, 10'd100, 9'd50, 1'b1); commit_req = 1'b1;
    tick();
    wr_valid = 1'b0; commit_req = 1'b0;
    chk("t2_pend", commit_pend, 1);
    chk("t2_ready_armed", wr_ready, 0);
    vs = 1'b0; tick();
    chk("t2_vblank", vblank_start, 1);
    chk("t2_done_early", commit_done, 0);
    tick();
    chk("t2_done", commit_done, 1);
    chk("t2_act_not_yet", act_x, 0);
    chk("t2_frame", frame_cnt, 1);
    vs = 1'b1; tick();
    chk("t2_act_x1", act_x[19:10], 100);
    chk("t2_act_y1", act_y[17:9], 50);
    chk("t2_act_vis", act_vis, 4'b0010);
    chk("t2_done_off", commit_done, 0);
    chk("t2_ready_back", wr_ready, 1);

    // Write held off while ARMED/COMMIT, lands afterwards
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    put(3'd0, 10'd7, 9'd8, 1'b1);
    tick(3);
    chk("t3_ready_stall", wr_ready, 0);
    chk("t3_pend", commit_pend, 1);
    vs = 1'b0; tick();
    tick();
    chk("t3_done", commit_done, 1);
    chk("t3_ready_commit", wr_ready, 0);
    vs = 1'b1; tick();
    chk("t3_ready_open", wr_ready, 1);
    chk("t3_act_x0_old", act_x[9:0], 0);
    chk("t3_act_vis_old", act_vis, 4'b0010);
    tick(); wr_valid = 1'b0;
    chk("t3_act_x0_hold", act_x[9:0], 0);
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    vs = 1'b0; tick(2); vs = 1'b1; tick();
    chk("t3_act_x0_new", act_x[9:0], 7);
    chk("t3_act_y0_new", act_y[8:0], 8);
    chk("t3_act_vis_new", act_vis, 4'b0011);
    chk("t3_frame", frame_cnt, 3);

    // commit_req coincident with vblank_start waits a whole frame
    vs = 1'b0; tick();
    chk("t4_vblank", vblank_start, 1);
    commit_req = 1'b1; tick(); commit_req = 1'b0; vs = 1'b1;
    chk("t4_pend", commit_pend, 1);
    chk("t4_no_done", commit_done, 0);
    chk("t4_frame_mid", frame_cnt, 4);
    seen = 0;
    repeat (4) begin tick(); if (commit_done) seen++; end
    chk("t4_no_early_commit", seen, 0);
    vs = 1'b0; tick(); tick();
    chk("t4_done", commit_done, 1);
    chk("t4_frame_end", frame_cnt, 5);
    vs = 1'b1; tick();

    // Frame counter wrap, preset close to the top
    force dut.frame_cnt_q = 16'hFFFE;
    tick();
    release dut.frame_cnt_q;
    tick();
    chk("t5_preset", frame_cnt, 16'hFFFE);
    vs = 1'b0; tick(2); vs = 1'b1; tick();
    chk("t5_ffff", frame_cnt, 16'hFFFF);
    vs = 1'b0; tick(2); vs = 1'b1; tick();
    chk("t5_wrap", frame_cnt, 16'h0000);

    // Out-of-range slot: accepted, dropped
    put(3'd5, 10'd511, 9'd300, 1'b1);
    chk("t5_ready_oob", wr_ready, 1);
    tick(); wr_valid = 1'b0;
    chk("t5_ready_after", wr_ready, 1);
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    vs = 1'b0; tick(2); vs = 1'b1; tick();
    ex_x = '0; ex_x[9:0] = 10'd7; ex_x[19:10] = 10'd100;
    ex_y = '0; ex_y[8:0] = 9'd8;  ex_y[17:9]  = 9'd50;
    chk("t5_act_x_same", act_x, ex_x);
    chk("t5_act_y_same", act_y, ex_y);
    chk("t5_act_vis_same", act_vis, 4'b0011);

    // Reset while ARMED discards the pending commit
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    chk("t1_pend_before", commit_pend, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_wr_ready", wr_ready, 1);
    chk("t1_pend", commit_pend, 0);
    chk("t1_act_x", act_x, 0);
    chk("t1_act_vis", act_vis, 0);
    chk("t1_frame", frame_cnt, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    vs = 1'b0; seen = 0;
    repeat (6) begin tick(); if (commit_done) seen++; end
    vs = 1'b1;
    chk("t1_no_commit", seen, 0);
    chk("t1_frame_after", frame_cnt, 1);
    tick();

`ifdef SPRITE_AUTO_COMMIT_EN
    // Dirty shadow commits at vsync without commit_req
    put(3'd3, 10'd300, 9'd200, 1'b1); tick(); wr_valid = 1'b0;
    vs = 1'b0; tick();
    chk("t6_vblank", vblank_start, 1);
    tick();
    chk("t6_auto_done", commit_done, 1);
    vs = 1'b1; tick();
    chk("t6_act_x3", act_x[39:30], 300);
    chk("t6_act_y3", act_y[35:27], 200);
    chk("t6_act_vis", act_vis, 4'b1000);
    vs = 1'b0; seen = 0;
    repeat (4) begin tick(); if (commit_done) seen++; end
    vs = 1'b1;
    chk("t6_clean_no_commit", seen, 0);
    chk("t6_frame", frame_cnt, 3);
`else
    // Without auto commit a vsync only counts
    put(3'd3, 10'd300, 9'd200, 1'b1); tick(); wr_valid = 1'b0;
    vs = 1'b0; seen = 0;
    repeat (4) begin tick(); if (commit_done) seen++; end
    vs = 1'b1;
    chk("t6_no_auto_commit", seen, 0);
    chk("t6_act_x", act_x, 0);
    chk("t6_act_vis", act_vis, 0);
    chk("t6_frame", frame_cnt, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
